rtc_bus_sequencer: RTL
======================

RTC_BUS_SEQUENCER -- requirements
Module: rtc_bus_sequencer

Interface
REQ-001 Parameter T_PH, default 4, cycles per bus phase; legal range 1..255.
REQ-002 Parameter T_GAP, default 2, idle cycles after each transaction; legal range 1..255.
REQ-003 clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_wr  in  1  write request; the requester holds it high until done_wr.
REQ-006 wr_addr  in  8  write register address; captured at grant.
REQ-007 wr_data  in  8  write data; captured at grant.
REQ-008 req_rd  in  1  read request; the requester holds it high until done_rd.
REQ-009 rd_addr  in  8  read register address; captured at grant.
REQ-010 ad_in  in  8  value read back from the shared AD bus.
REQ-011 ad_out  out  8  value driven onto the AD bus.
REQ-012 ad_oe  out  1  enable for the bus mux/tri-state driver.
REQ-013 mux_sel  out  1  mux select: 0 = address channel, 1 = data channel.
REQ-014 cs_n, rd_n, wr_n  out  1 each  RTC chip select and strobes, active-low.
REQ-015 a_d  out  1  address/data line: 0 = address phase, 1 = data phase.
REQ-016 rd_data  out  8  registered read result.
REQ-017 done_wr, done_rd  out  1 each  one-cycle completion pulses.
REQ-018 busy  out  1  high whenever the state is not IDLE.

Function
REQ-019 All outputs shall be registered.
REQ-020 The FSM states shall be IDLE, ADDR_SETUP, ADDR_STROBE, ADDR_HOLD, DATA_SETUP, DATA_STROBE, DATA_HOLD and GAP.
REQ-021 Each state from ADDR_SETUP through DATA_HOLD shall last exactly T_PH cycles. GAP shall last T_GAP cycles. Each state then advances to the next, and GAP returns to IDLE.
REQ-022 Requests shall be sampled only in IDLE. A request seen in IDLE shall move the FSM to ADDR_SETUP on the next edge and capture the address and data. Requests during a transaction shall be ignored until the FSM returns to IDLE.
REQ-023 Arbitration shall be round-robin. If both requests are high, the grant goes to the type not granted last. After reset, "last granted" shall be read, so write wins the first tie. With a single request, that request is granted.
REQ-024 IDLE and GAP drive: cs_n=1, rd_n=1, wr_n=1, a_d=1, ad_oe=0, mux_sel=0, ad_out=0x00.
REQ-025 Address states (ADDR_SETUP, ADDR_STROBE, ADDR_HOLD) drive: cs_n=0, a_d=0, mux_sel=0, ad_oe=1, ad_out=captured address. wr_n=0 only in ADDR_STROBE.
REQ-026 Data states for a write drive: cs_n=0, a_d=1, mux_sel=1, ad_oe=1, ad_out=captured data. wr_n=0 only in DATA_STROBE.
REQ-027 Data states for a read drive: cs_n=0, a_d=1, mux_sel=1, ad_oe=0. rd_n=0 only in DATA_STROBE.
REQ-028 rd_data shall load ad_in on the last cycle of read DATA_STROBE and hold it until the next read completes or reset.
REQ-029 done_wr or done_rd shall pulse for exactly the first cycle of GAP; there is no pulse for the other type.
REQ-030 Timing, counting cycle 1 as the first ADDR_SETUP cycle: the transaction occupies 6*T_PH + T_GAP cycles, and the done pulse falls at cycle 6*T_PH + 1.
REQ-031 Invariants: rd_n and wr_n are never both 0; ad_oe=0 whenever rd_n=0; a_d and mux_sel change only at phase boundaries.
REQ-032 The phase counter shall be 8 bits and reload at each state entry; no wrap occurs within the legal parameter range.

Reset
REQ-033 Reset in any state shall force, on the next edge: IDLE, all outputs to REQ-024 values, rd_data=0x00, busy=0, done pulses 0, last-granted=read.
REQ-034 A transaction aborted by reset shall produce no done pulse and shall not update rd_data.

Verification (T_PH=4, T_GAP=2)
REQ-035 Write: req_wr with wr_addr=0x21, wr_data=0x15 -> ad_out=0x21 with a_d=0 in cycles 1-12; wr_n=0 in cycles 5-8; ad_out=0x15 with a_d=1 in cycles 13-24; wr_n=0 in cycles 17-20; done_wr at cycle 25; busy high in cycles 1-26.
REQ-036 Read: req_rd with rd_addr=0x22, ad_in=0x59 in cycles 17-20 -> rd_n=0 in cycles 17-20; ad_oe=0 from cycle 13; rd_data=0x59 with done_rd at cycle 25.
REQ-037 Both requests held after reset -> grant order write, read, write, read, with done pulses alternating.
REQ-038 Reset asserted at cycle 18 of a write -> next cycle: cs_n=1, wr_n=1, ad_oe=0, busy=0; no done_wr.
REQ-039 req_rd rising at cycle 10 of a write -> the read starts only on the cycle after the write's GAP ends; no bus overlap.
REQ-040 ad_in=0xAA in cycles 17-19, then 0x3C in cycle 20 -> rd_data=0x3C.

Source files
------------

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: arbitrates write/read requests and sequences RTC
// multiplexed address/data bus cycles (address phase, data phase, idle gap).
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   req_wr/wr_addr/wr_data   write request, held until done_wr
//   req_rd/rd_addr           read request, held until done_rd
//   ad_in               value read back from the AD bus
//   ad_out, ad_oe       AD bus drive value and output enable
//   mux_sel             0 = address channel, 1 = data channel
//   cs_n, rd_n, wr_n    RTC chip select and strobes (active-low)
//   a_d                 0 = address phase, 1 = data phase
//   rd_data             registered read result
//   done_wr, done_rd    one-cycle completion pulses (first GAP cycle)
//   busy                high whenever the sequencer is not idle
module rtc_bus_sequencer #(
    parameter int unsigned T_PH  = 4,
    parameter int unsigned T_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_wr,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       req_rd,
    input  logic [7:0] rd_addr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       mux_sel,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d,
    output logic [7:0] rd_data,
    output logic       done_wr,
    output logic       done_rd,
    output logic       busy
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] PH_LOAD  = CNT_W'(T_PH - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(T_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        ADDR_STROBE,
        ADDR_HOLD,
        DATA_SETUP,
        DATA_STROBE,
        DATA_HOLD,
        GAP
    } state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               op_rd, op_rd_nx;
    logic               last_rd, last_rd_nx;
    logic [DATA_W-1:0]  addr_q, addr_nx;
    logic [DATA_W-1:0]  data_q, data_nx;
    logic               done_wr_nx, done_rd_nx;
    logic               rd_load;

    // Next-state, arbitration and phase counter
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        op_rd_nx   = op_rd;
        last_rd_nx = last_rd;
        addr_nx    = addr_q;
        data_nx    = data_q;
        done_wr_nx = 1'b0;
        done_rd_nx = 1'b0;
        rd_load    = 1'b0;

        case (state)
            IDLE: begin
                // Round-robin: on a tie the type not granted last wins
                if (req_wr && (!req_rd || last_rd)) begin
                    state_nx   = ADDR_SETUP;
                    cnt_nx     = PH_LOAD;
                    op_rd_nx   = 1'b0;
                    last_rd_nx = 1'b0;
                    addr_nx    = wr_addr;
                    data_nx    = wr_data;
                end else if (req_rd) begin
                    state_nx   = ADDR_SETUP;
                    cnt_nx     = PH_LOAD;
                    op_rd_nx   = 1'b1;
                    last_rd_nx = 1'b1;
                    addr_nx    = rd_addr;
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                if (cnt == '0) begin
                    cnt_nx = PH_LOAD;
                    case (state)
                        ADDR_SETUP:  state_nx = ADDR_STROBE;
                        ADDR_STROBE: state_nx = ADDR_HOLD;
                        ADDR_HOLD:   state_nx = DATA_SETUP;
                        DATA_SETUP:  state_nx = DATA_STROBE;
                        DATA_STROBE: state_nx = DATA_HOLD;
                        default: begin
                            state_nx   = GAP;
                            cnt_nx     = GAP_LOAD;
                            done_wr_nx = !op_rd;
                            done_rd_nx = op_rd;
                        end
                    endcase
                    rd_load = (state == DATA_STROBE) && op_rd;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
        endcase
    end

    // State register; outputs are registered from the upcoming state so
    // they line up with the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            op_rd   <= 1'b0;
            last_rd <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
            rd_data <= '0;
            done_wr <= 1'b0;
            done_rd <= 1'b0;
            busy    <= 1'b0;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b1;
            ad_oe   <= 1'b0;
            mux_sel <= 1'b0;
            ad_out  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            op_rd   <= op_rd_nx;
            last_rd <= last_rd_nx;
            addr_q  <= addr_nx;
            data_q  <= data_nx;
            done_wr <= done_wr_nx;
            done_rd <= done_rd_nx;
            busy    <= (state_nx != IDLE);
            if (rd_load) begin
                rd_data <= ad_in;
            end

            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            a_d     <= 1'b1;
            ad_oe   <= 1'b0;
            mux_sel <= 1'b0;
            ad_out  <= '0;

            case (state_nx)
                ADDR_SETUP, ADDR_STROBE, ADDR_HOLD: begin
                    cs_n    <= 1'b0;
                    a_d     <= 1'b0;
                    ad_oe   <= 1'b1;
                    ad_out  <= addr_nx;
                    wr_n    <= (state_nx != ADDR_STROBE);
                end
                DATA_SETUP, DATA_STROBE, DATA_HOLD: begin
                    cs_n    <= 1'b0;
                    mux_sel <= 1'b1;
                    if (op_rd_nx) begin
                        rd_n <= (state_nx != DATA_STROBE);
                    end else begin
                        ad_oe  <= 1'b1;
                        ad_out <= data_nx;
                        wr_n   <= (state_nx != DATA_STROBE);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
